// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle RISC_CPU control unit:
// opcode values and the control-state encoding.
package cpu_pkg;

  localparam int unsigned OP_NOP   = 0;
  localparam int unsigned OP_ADD   = 1;
  localparam int unsigned OP_SUB   = 2;
  localparam int unsigned OP_STORE = 3;
  localparam int unsigned OP_LOAD  = 4;
  localparam int unsigned OP_AND   = 5;
  localparam int unsigned OP_OR    = 6;
  localparam int unsigned OP_HALT  = 63;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_MEM  = 3'd2,
    ST_WB   = 3'd3,
    ST_ERR  = 3'd4,
    ST_HALT = 3'd5
  } state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting for a data-memory acknowledge.
// expire is high during the MEM_TIMEOUT-th waiting cycle (count
// cleared on entry, so that cycle sees count == MEM_TIMEOUT-1).
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] cnt_reg;

  // Wait counter: clear has priority over enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (enable) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign expire = (cnt_reg == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/control_unit_seq.sv
// Multi-cycle control unit: valid/ready instruction intake, Moore FSM,
// data-memory handshake with timeout, load write-back, illegal/halt
// reporting and a retired-instruction counter.
module control_unit_seq
  import cpu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int OP_W        = 6,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] instr,
  input  logic              dm_ack,
  output logic              rf_we,
  output logic              dm_we,
  output logic              dm_re,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] instr_q,
  output logic              illegal,
  output logic              mem_err,
  output logic              halted,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam logic [OP_W-1:0] C_NOP   = OP_W'(OP_NOP);
  localparam logic [OP_W-1:0] C_ADD   = OP_W'(OP_ADD);
  localparam logic [OP_W-1:0] C_SUB   = OP_W'(OP_SUB);
  localparam logic [OP_W-1:0] C_STORE = OP_W'(OP_STORE);
  localparam logic [OP_W-1:0] C_LOAD  = OP_W'(OP_LOAD);
  localparam logic [OP_W-1:0] C_AND   = OP_W'(OP_AND);
  localparam logic [OP_W-1:0] C_OR    = OP_W'(OP_OR);
  localparam logic [OP_W-1:0] C_HALT  = OP_W'(OP_HALT);

  state_e              state_reg, state_next;
  logic [OP_W-1:0]     op_reg, op_next;
  logic [DATA_W-1:0]   instr_reg, instr_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;

  logic timer_clear, timer_enable, timer_expire;
  logic op_alu, op_nop, op_store, op_load, op_halt;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expire (timer_expire)
  );

  // Classify the latched opcode; anything unmatched is illegal.
  always_comb begin
    op_alu   = (op_reg == C_ADD) || (op_reg == C_SUB) ||
               (op_reg == C_AND) || (op_reg == C_OR);
    op_nop   = (op_reg == C_NOP);
    op_store = (op_reg == C_STORE);
    op_load  = (op_reg == C_LOAD);
    op_halt  = (op_reg == C_HALT);
  end

  // State, latched instruction and retire counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      op_reg    <= '0;
      instr_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      instr_reg <= instr_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic plus Moore output decode from state_reg/op_reg.
  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    instr_next   = instr_reg;
    cnt_next     = cnt_reg;
    timer_clear  = 1'b0;
    timer_enable = 1'b0;
    rf_we        = 1'b0;
    dm_we        = 1'b0;
    dm_re        = 1'b0;
    illegal      = 1'b0;
    mem_err      = 1'b0;
    halted       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (instr_valid) begin
          op_next    = opcode;
          instr_next = instr;
          state_next = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (op_alu) begin
          rf_we      = 1'b1;
          cnt_next   = cnt_reg + CNT_W'(1);
          state_next = ST_IDLE;
        end else if (op_nop) begin
          cnt_next   = cnt_reg + CNT_W'(1);
          state_next = ST_IDLE;
        end else if (op_store || op_load) begin
          timer_clear = 1'b1;
          state_next  = ST_MEM;
        end else if (op_halt) begin
          // HALT retires exactly once, on the way into the halt state.
          cnt_next   = cnt_reg + CNT_W'(1);
          state_next = ST_HALT;
        end else begin
          illegal    = 1'b1;
          state_next = ST_IDLE;
        end
      end

      ST_MEM: begin
        dm_we = op_store;
        dm_re = op_load;
        // Acknowledge is checked before the timeout so a last-cycle ack succeeds.
        if (dm_ack) begin
          if (op_store) begin
            cnt_next   = cnt_reg + CNT_W'(1);
            state_next = ST_IDLE;
          end else begin
            state_next = ST_WB;
          end
        end else if (timer_expire) begin
          state_next = ST_ERR;
        end else begin
          timer_enable = 1'b1;
        end
      end

      ST_WB: begin
        rf_we      = 1'b1;
        cnt_next   = cnt_reg + CNT_W'(1);
        state_next = ST_IDLE;
      end

      ST_ERR: begin
        mem_err    = 1'b1;
        state_next = ST_IDLE;
      end

      ST_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Ready only in IDLE, and held low while reset is asserted.
  assign instr_ready = (state_reg == ST_IDLE) && reset;
  assign alu_op      = op_reg;
  assign instr_q     = instr_reg;
  assign retire_cnt  = cnt_reg;

endmodule

// File: tb/tb_control_unit_seq.sv
module tb_control_unit_seq;

  localparam int DATA_W      = 32;
  localparam int OP_W        = 6;
  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 4;

  logic              clk;
  logic              reset;
  logic              instr_valid;
  logic              instr_ready;
  logic [OP_W-1:0]   opcode;
  logic [DATA_W-1:0] instr;
  logic              dm_ack;
  logic              rf_we, dm_we, dm_re;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] instr_q;
  logic              illegal, mem_err, halted;
  logic [CNT_W-1:0]  retire_cnt;

  control_unit_seq #(
    .DATA_W(DATA_W), .OP_W(OP_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .instr(instr), .dm_ack(dm_ack), .rf_we(rf_we), .dm_we(dm_we),
    .dm_re(dm_re), .alu_op(alu_op), .instr_q(instr_q), .illegal(illegal),
    .mem_err(mem_err), .halted(halted), .retire_cnt(retire_cnt)
  );

  typedef struct packed {
    logic              rdy;
    logic              rf;
    logic              dw;
    logic              dr;
    logic              ill;
    logic              merr;
    logic              hlt;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] ins;
    logic [CNT_W-1:0]  cnt;
  } vec_t;

  vec_t  exp_q[$];
  string nm_q[$];

  int n_vec  = 0;
  int n_miss = 0;

  logic [OP_W-1:0]   m_op;
  logic [DATA_W-1:0] m_ins;
  logic [CNT_W-1:0]  m_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (actual running, required finished)");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    vec_t  e;
    vec_t  a;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      a.rdy  = instr_ready;
      a.rf   = rf_we;
      a.dw   = dm_we;
      a.dr   = dm_re;
      a.ill  = illegal;
      a.merr = mem_err;
      a.hlt  = halted;
      a.op   = alu_op;
      a.ins  = instr_q;
      a.cnt  = retire_cnt;
      n_vec++;
      if (a !== e) begin
        n_miss++;
        $display("FAIL %s @%0t actual rdy=%b rf=%b dw=%b dr=%b ill=%b merr=%b hlt=%b op=%0d ins=%h cnt=%0d required rdy=%b rf=%b dw=%b dr=%b ill=%b merr=%b hlt=%b op=%0d ins=%h cnt=%0d",
                 n, $time, a.rdy, a.rf, a.dw, a.dr, a.ill, a.merr, a.hlt, a.op, a.ins, a.cnt,
                 e.rdy, e.rf, e.dw, e.dr, e.ill, e.merr, e.hlt, e.op, e.ins, e.cnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string nm, input logic rdy, input logic rf, input logic dw,
                      input logic dr, input logic ill, input logic merr, input logic hlt);
    vec_t e;
    e.rdy  = rdy;
    e.rf   = rf;
    e.dw   = dw;
    e.dr   = dr;
    e.ill  = ill;
    e.merr = merr;
    e.hlt  = hlt;
    e.op   = m_op;
    e.ins  = m_ins;
    e.cnt  = m_cnt;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic clear_model();
    m_op  = '0;
    m_ins = '0;
    m_cnt = '0;
  endtask

  task automatic do_reset();
    $display("txn RESET");
    reset = 1'b0;
    clear_model();
    push("reset0", 0, 0, 0, 0, 0, 0, 0);
    tick();
    push("reset1", 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    #1;
    if (instr_ready !== 1'b1) begin
      n_miss++;
      $display("FAIL post-reset-ready @%0t actual instr_ready=%b required instr_ready=1", $time, instr_ready);
    end
  endtask

  task automatic accept(input string nm, input logic [OP_W-1:0] op, input logic [DATA_W-1:0] ins);
    $display("txn %s op=%0d instr=%h", nm, op, ins);
    push({nm, "/idle"}, 1, 0, 0, 0, 0, 0, 0);
    instr_valid = 1'b1;
    opcode      = op;
    instr       = ins;
    tick();
    instr_valid = 1'b0;
    m_op  = op;
    m_ins = ins;
  endtask

  task automatic exec1(input string nm, input logic [OP_W-1:0] op, input logic [DATA_W-1:0] ins,
                       input logic rf, input logic ill, input logic retire);
    accept(nm, op, ins);
    push({nm, "/exec"}, 0, rf, 0, 0, ill, 0, 0);
    tick();
    if (retire) m_cnt = m_cnt + 1'b1;
  endtask

  task automatic mem_op(input string nm, input logic [OP_W-1:0] op, input logic [DATA_W-1:0] ins,
                        input int ack_at);
    logic is_store;
    logic acked;
    is_store = (op == 6'd3);
    acked    = 1'b0;
    accept(nm, op, ins);
    push({nm, "/exec"}, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 1; i <= MEM_TIMEOUT; i++) begin
      push($sformatf("%s/mem%0d", nm, i), 0, 0, is_store, !is_store, 0, 0, 0);
      dm_ack = (i == ack_at);
      tick();
      dm_ack = 1'b0;
      if (i == ack_at) begin
        acked = 1'b1;
        break;
      end
    end
    if (acked) begin
      if (!is_store) begin
        push({nm, "/wb"}, 0, 1, 0, 0, 0, 0, 0);
        tick();
      end
      m_cnt = m_cnt + 1'b1;
    end else begin
      push({nm, "/err"}, 0, 0, 0, 0, 0, 1, 0);
      tick();
    end
  endtask

  task automatic do_halt(input logic [DATA_W-1:0] ins);
    accept("HALT", 6'd63, ins);
    push("HALT/exec", 0, 0, 0, 0, 0, 0, 0);
    tick();
    m_cnt = m_cnt + 1'b1;
    for (int i = 0; i < 20; i++) begin
      instr_valid = 1'b1;
      opcode      = 6'd1;
      instr       = 32'hDEAD_0000 + 32'(i);
      push($sformatf("HALT/hold%0d", i), 0, 0, 0, 0, 0, 0, 1);
      tick();
    end
    instr_valid = 1'b0;
  endtask

  task automatic store_then_reset();
    accept("STORE-rst", 6'd3, 32'h0000_5A5A);
    push("STORE-rst/exec", 0, 0, 0, 0, 0, 0, 0);
    tick();
    push("STORE-rst/mem1", 0, 0, 1, 0, 0, 0, 0);
    tick();
    push("STORE-rst/mem2", 0, 0, 1, 0, 0, 0, 0);
    tick();
    clear_model();
    push("async-reset", 0, 0, 0, 0, 0, 0, 0);
    #1 reset = 1'b0;
    tick();
    push("async-reset-hold", 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    push("post-reset-idle", 1, 0, 0, 0, 0, 0, 0);
    tick();
    if (retire_cnt !== '0) begin
      n_miss++;
      $display("FAIL reset-cnt @%0t actual retire_cnt=%0d required retire_cnt=0", $time, retire_cnt);
    end
    if (instr_ready !== 1'b1) begin
      n_miss++;
      $display("FAIL reset-idle @%0t actual instr_ready=%b required instr_ready=1", $time, instr_ready);
    end
  endtask

  initial begin
    reset       = 1'b0;
    instr_valid = 1'b0;
    opcode      = '0;
    instr       = '0;
    dm_ack      = 1'b0;
    clear_model();
    tick();
    do_reset();

    exec1("ADD", 6'd1, 32'h0000_1234, 1, 0, 1);
    mem_op("STORE-ack4", 6'd3, 32'h0000_0A03, 4);
    mem_op("LOAD-ack1", 6'd4, 32'h0000_0B04, 1);
    mem_op("LOAD-timeout", 6'd4, 32'h0000_0C04, 0);
    mem_op("LOAD-ack15", 6'd4, 32'h0000_0D04, 15);
    mem_op("STORE-timeout", 6'd3, 32'h0000_0E03, 0);
    exec1("SUB", 6'd2, 32'hFFFF_0002, 1, 0, 1);
    exec1("AND", 6'd5, 32'h8000_0005, 1, 0, 1);
    exec1("OR", 6'd6, 32'h1357_9BDF, 1, 0, 1);
    exec1("NOP", 6'd0, 32'h0000_0000, 0, 0, 1);
    exec1("ILLEGAL9", 6'd9, 32'h0000_0909, 0, 1, 0);
    exec1("ILLEGAL62", 6'd62, 32'h0000_3E3E, 0, 1, 0);
    do_halt(32'hFC00_0000);
    do_reset();

    for (int i = 0; i < 17; i++) begin
      exec1($sformatf("NOP%0d", i), 6'd0, 32'(i), 0, 0, 1);
    end

    store_then_reset();

    #10;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    if (n_vec == 0) begin
      $display("FAIL coverage: actual vectors=0 required vectors>0");
    end
    if (n_miss != 0) begin
      $display("FAIL summary: actual miscompares=%0d required miscompares=0", n_miss);
    end else begin
      $display("PASS");
    end
    $finish;
  end

endmodule
